// File: rtl/regfile_param_if.sv
// regfile_param_if
//   Bus bundle for the parametrised register file.
//   master : drives write enable/address/data and the two read addresses,
//            receives the registered read data and the ready flag.
//   slave  : the register file side of the same bundle.
//   Signals:
//     regWrite   write enable (only honoured once ready is high)
//     rd         write address, AW bits
//     writeData  write data, XLEN bits
//     rs1, rs2   read addresses, AW bits
//     readData1  registered read data for rs1
//     readData2  registered read data for rs2
//     ready      high once the post-reset clear sweep has finished
interface regfile_param_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            regWrite;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] writeData;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic            ready;

  modport master (
    output regWrite, rd, writeData, rs1, rs2,
    input  readData1, readData2, ready
  );

  modport slave (
    input  regWrite, rd, writeData, rs1, rs2,
    output readData1, readData2, ready
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param
//   Parametrised register file: one write port, two registered read ports,
//   write-first forwarding, optional hardwired-zero entry 0 and a post-reset
//   sweep that zeroes every entry before ready is raised.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset; restarts the clear sweep
//     bus    regfile_param_if slave modport (write port, read ports, ready)
module regfile_param #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           reset,
  regfile_param_if.slave bus
);

  localparam logic [AW:0] NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] readData1_q, readData1_d;
  logic [XLEN-1:0] readData2_q, readData2_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic            memWe;
  logic [AW-1:0]   memAddr;
  logic [XLEN-1:0] memData;
  logic            writeOk;

  // An address maps to real storage only if it is in range and is not the
  // hardwired-zero entry. Out-of-range addresses are compared at full width
  // so they can never alias onto a valid entry.
  function automatic logic addrBacked(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !(HAS_ZERO && (a == '0));
  endfunction

  // Next-state logic: the sweep owns the write port while clearing; in RUN
  // the write port follows the bus and reads are write-first forwarded.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    readData1_d = '0;
    readData2_d = '0;
    memWe       = 1'b0;
    memAddr     = cnt_q[AW-1:0];
    memData     = '0;
    writeOk     = 1'b0;

    case (state_q)
      CLEAR: begin
        memWe = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        writeOk = bus.regWrite && addrBacked(bus.rd);
        memWe   = writeOk;
        memAddr = bus.rd;
        memData = bus.writeData;
        if (writeOk && (bus.rs1 == bus.rd)) begin
          readData1_d = bus.writeData;
        end else if (addrBacked(bus.rs1)) begin
          readData1_d = mem_q[bus.rs1];
        end
        if (writeOk && (bus.rs2 == bus.rd)) begin
          readData2_d = bus.writeData;
        end else if (addrBacked(bus.rs2)) begin
          readData2_d = mem_q[bus.rs2];
        end
      end
      default: state_d = CLEAR;
    endcase

    // Storage is left untouched on reset edges.
    if (reset) begin
      memWe = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      readData1_q <= '0;
      readData2_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      readData1_q <= readData1_d;
      readData2_q <= readData2_d;
    end
  end

  // Entry storage has no reset; the sweep provides its initial zeroes.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memAddr] <= memData;
    end
  end

  assign bus.readData1 = readData1_q;
  assign bus.readData2 = readData2_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Self-checking bench for regfile_param. Three instances share clock,
//   reset and read addresses; writes are steered to one instance by sel:
//     u0: 32 entries, hardwired zero
//     u1: 32 entries, entry 0 ordinary
//     u2: 18 entries, hardwired zero (bounds behaviour)
module tb_regfile_param;

  logic        clk;
  logic        reset;
  int          sel;
  logic        regWrite;
  logic [4:0]  rd;
  logic [63:0] writeData;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int compareCount;
  int mismatchCount;

  typedef struct {
    int          sel;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t vecs[$];

  regfile_param_if #(.XLEN(64), .AW(5)) bus0 ();
  regfile_param_if #(.XLEN(64), .AW(5)) bus1 ();
  regfile_param_if #(.XLEN(64), .AW(5)) bus2 ();

  // Writes only reach the selected instance; reads go to all of them.
  assign bus0.regWrite  = regWrite && (sel == 0);
  assign bus1.regWrite  = regWrite && (sel == 1);
  assign bus2.regWrite  = regWrite && (sel == 2);
  assign bus0.rd        = rd;
  assign bus1.rd        = rd;
  assign bus2.rd        = rd;
  assign bus0.writeData = writeData;
  assign bus1.writeData = writeData;
  assign bus2.writeData = writeData;
  assign bus0.rs1       = rs1;
  assign bus1.rs1       = rs1;
  assign bus2.rs1       = rs1;
  assign bus0.rs2       = rs2;
  assign bus1.rs2       = rs2;
  assign bus2.rs2       = rs2;

  regfile_param #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(1)) u0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  regfile_param #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(0)) u1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  regfile_param #(.XLEN(64), .NREGS(18), .AW(5), .ZERO_REG(1)) u2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic applyStimulus(input int s, input logic we, input logic [4:0] a,
                               input logic [63:0] d, input logic [4:0] r1,
                               input logic [4:0] r2);
    @(negedge clk);
    sel       = s;
    regWrite  = we;
    rd        = a;
    writeData = d;
    rs1       = r1;
    rs2       = r2;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    sel       = 0;
    regWrite  = 1'b0;
    rd        = '0;
    writeData = '0;
    rs1       = '0;
    rs2       = '0;
    reset     = 1'b1;

    // u0: basic write/read, forwarding, zero register
    vecs.push_back('{0, 1'b1, 5'd5,  64'hDEAD_BEEF_0000_0005, 5'd1, 5'd0, 64'h0, 64'h0});
    vecs.push_back('{0, 1'b0, 5'd0,  64'h0,    5'd5, 5'd5, 64'hDEAD_BEEF_0000_0005, 64'hDEAD_BEEF_0000_0005});
    vecs.push_back('{0, 1'b1, 5'd7,  64'h11,   5'd0, 5'd0, 64'h0,  64'h0});
    vecs.push_back('{0, 1'b1, 5'd8,  64'h33,   5'd7, 5'd7, 64'h11, 64'h11});
    vecs.push_back('{0, 1'b1, 5'd7,  64'h22,   5'd7, 5'd7, 64'h22, 64'h22});
    vecs.push_back('{0, 1'b1, 5'd7,  64'h44,   5'd7, 5'd8, 64'h44, 64'h33});
    vecs.push_back('{0, 1'b0, 5'd0,  64'h0,    5'd7, 5'd8, 64'h44, 64'h33});
    vecs.push_back('{0, 1'b1, 5'd0,  64'hFFFF, 5'd0, 5'd0, 64'h0,  64'h0});
    vecs.push_back('{0, 1'b0, 5'd0,  64'h0,    5'd0, 5'd5, 64'h0,  64'hDEAD_BEEF_0000_0005});
    // u1: entry 0 is ordinary
    vecs.push_back('{1, 1'b1, 5'd0,  64'hFFFF, 5'd0, 5'd1, 64'hFFFF, 64'h0});
    vecs.push_back('{1, 1'b0, 5'd0,  64'h0,    5'd0, 5'd0, 64'hFFFF, 64'hFFFF});
    vecs.push_back('{1, 1'b1, 5'd31, 64'h1234, 5'd31, 5'd0, 64'h1234, 64'hFFFF});
    vecs.push_back('{1, 1'b0, 5'd0,  64'h0,    5'd31, 5'd5, 64'h1234, 64'h0});
    // u2: out-of-range accesses, last valid entry
    vecs.push_back('{2, 1'b1, 5'd20, 64'hAA,   5'd20, 5'd4,  64'h0,  64'h0});
    vecs.push_back('{2, 1'b0, 5'd0,  64'h0,    5'd4,  5'd20, 64'h0,  64'h0});
    vecs.push_back('{2, 1'b1, 5'd17, 64'h77,   5'd17, 5'd16, 64'h77, 64'h0});
    vecs.push_back('{2, 1'b0, 5'd0,  64'h0,    5'd17, 5'd4,  64'h77, 64'h0});
    vecs.push_back('{2, 1'b1, 5'd31, 64'hBB,   5'd1,  5'd17, 64'h0,  64'h77});

    // Reset held for three edges
    repeat (3) waitEdge();
    checkOutput("reset_ready",     {63'd0, bus0.ready}, 64'd0);
    checkOutput("reset_readData1", bus0.readData1, 64'd0);
    checkOutput("reset_readData2", bus0.readData2, 64'd0);

    // Sweep timing: ready at edge 32 for 32 entries, edge 18 for 18 entries
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      waitEdge();
      checkOutput($sformatf("sweep_u0_ready_e%0d", e), {63'd0, bus0.ready}, (e >= 32) ? 64'd1 : 64'd0);
      checkOutput($sformatf("sweep_u1_ready_e%0d", e), {63'd0, bus1.ready}, (e >= 32) ? 64'd1 : 64'd0);
      checkOutput($sformatf("sweep_u2_ready_e%0d", e), {63'd0, bus2.ready}, (e >= 18) ? 64'd1 : 64'd0);
    end

    // Every entry reads zero after the sweep
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      checkOutput($sformatf("zero_u0_rs1_%0d", i), bus0.readData1, 64'd0);
      checkOutput($sformatf("zero_u0_rs2_%0d", i), bus0.readData2, 64'd0);
      checkOutput($sformatf("zero_u1_rs1_%0d", i), bus1.readData1, 64'd0);
      checkOutput($sformatf("zero_u2_rs1_%0d", i), bus2.readData1, 64'd0);
    end

    // Directed vector table
    foreach (vecs[k]) begin
      logic [63:0] got1;
      logic [63:0] got2;
      logic        gotReady;
      applyStimulus(vecs[k].sel, vecs[k].we, vecs[k].rd, vecs[k].wd,
                    vecs[k].rs1, vecs[k].rs2);
      case (vecs[k].sel)
        0:       begin got1 = bus0.readData1; got2 = bus0.readData2; gotReady = bus0.ready; end
        1:       begin got1 = bus1.readData1; got2 = bus1.readData2; gotReady = bus1.ready; end
        default: begin got1 = bus2.readData1; got2 = bus2.readData2; gotReady = bus2.ready; end
      endcase
      checkOutput($sformatf("vec%0d_readData1", k), got1, vecs[k].e1);
      checkOutput($sformatf("vec%0d_readData2", k), got2, vecs[k].e2);
      checkOutput($sformatf("vec%0d_ready", k), {63'd0, gotReady}, 64'd1);
    end

    // Reset mid-run: entry 3 holds 0x55, then reset with a colliding write
    applyStimulus(0, 1'b1, 5'd3, 64'h55, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    rs1   = 5'd3;
    rs2   = 5'd3;
    waitEdge();
    checkOutput("midreset_readData1", bus0.readData1, 64'd0);
    checkOutput("midreset_readData2", bus0.readData2, 64'd0);
    checkOutput("midreset_ready", {63'd0, bus0.ready}, 64'd0);

    // regWrite stays high through the whole re-sweep and must be ignored
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      waitEdge();
      checkOutput($sformatf("resweep_ready_e%0d", e), {63'd0, bus0.ready}, (e >= 32) ? 64'd1 : 64'd0);
      checkOutput($sformatf("resweep_readData1_e%0d", e), bus0.readData1, 64'd0);
    end

    applyStimulus(0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7);
    checkOutput("after_resweep_entry3", bus0.readData1, 64'd0);
    checkOutput("after_resweep_entry7", bus0.readData2, 64'd0);
    checkOutput("after_resweep_ready", {63'd0, bus0.ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-entry register file with two registered read ports and one write port. It replaces the fixed 64-bit, 18-entry file in the integer datapath. Relative to that file it adds configurable width and depth, an optional hardwired-zero entry 0, and write-to-read forwarding on the same edge. It also adds a post-reset clear sweep: the block raises `ready` only once every entry is zero, so the file needs no simulation-only initialisation.

## Interface
Parameters:
- `XLEN`, default 64: data width of each entry.
- `NREGS`, default 32: number of entries; must satisfy 2 ≤ NREGS ≤ 2**AW.
- `AW`, default 5: address width of `rs1`, `rs2` and `rd`.
- `ZERO_REG`, default 1: when 1, entry 0 always reads 0 and writes to it are discarded.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `regWrite`  in  1: write enable; honoured only when `ready`=1.
- `rd`  in  AW: write address.
- `writeData`  in  XLEN: write data.
- `rs1`, `rs2`  in  AW: read addresses.
- `readData1`, `readData2`  out  XLEN: registered read data.
- `ready`  out  1: high once the clear sweep is complete.

## Operation
- State machine with two states:
  - CLEAR: entered on reset.
  - RUN: normal operation.
- Sweep counter `cnt` has width AW+1.
- While `reset`=1 at an edge:
  - state becomes CLEAR, `cnt` becomes 0;
  - `ready`, `readData1` and `readData2` become 0;
  - entry contents are left untouched.
- CLEAR behaviour, at each edge with `reset`=0:
  - entry[`cnt`] is written with 0 and `cnt` increments;
  - the edge that clears entry NREGS-1 moves the state to RUN and sets `ready`=1;
  - `regWrite` is ignored;
  - `readData1` and `readData2` are driven with 0.
- RUN behaviour, at each edge:
  - readDataN is loaded from entry[rsN].
  - If `regWrite`=1, `rd` < NREGS, and not (ZERO_REG=1 and `rd`=0), then entry[`rd`] ← `writeData`.
- Forwarding: if an enabled write is accepted on the same edge and `rd`==rsN, readDataN is loaded with `writeData` (write-first), not the old contents. This applies to both ports independently, including when `rs1`==`rs2`==`rd`.
- Out-of-range addresses:
  - a read with rsN ≥ NREGS returns 0;
  - a write with `rd` ≥ NREGS is discarded and never aliases onto a valid entry.
- With ZERO_REG=1, a read of entry 0 returns 0 regardless of any write, and no forwarding occurs for `rd`=0.
- With ZERO_REG=0, entry 0 behaves as an ordinary entry.
- Reset asserted mid-sweep or mid-run restarts the sweep from entry 0. Entries already written stay stale until the sweep reaches them, and cannot be read because `ready`=0.

## Timing
- Read latency is 1 cycle. Addresses presented before edge N produce data valid after edge N and held until edge N+1.
- Write latency is 1 cycle. Data written at edge N is visible:
  - at edge N via forwarding;
  - at edge N+1 and later via storage.
- Reset values: `ready`=0, `readData1`=0, `readData2`=0.
- `ready` rises after exactly NREGS edges with `reset`=0 following the last reset edge. It then stays high until the next reset.
- No combinational path exists from any input to any output.

## Test plan
- Sweep timing (XLEN=64, NREGS=32): hold `reset` 3 cycles, then release. `ready`=0 for edges 1–31 and rises at edge 32. Once `ready`=1, reading every entry returns 0.
- Basic write/read: write 0xDEAD_BEEF_0000_0005 to rd=5 at edge N. Read rs1=5 at edge N+1. `readData1`=0xDEAD_BEEF_0000_0005 after edge N+1.
- Forwarding and read-before-write of the old value:
  - entry 7 holds 0x11;
  - at one edge, write 0x22 to rd=7 with rs1=7 and rs2=7;
  - both outputs = 0x22 after that edge.
  - Repeat with rs2=8 holding 0x33: `readData2`=0x33.
- Zero register: ZERO_REG=1, write 0xFFFF to rd=0 with rs1=0 on the same edge, then read again the next cycle. `readData1`=0 both times. With ZERO_REG=0 the same sequence returns 0xFFFF on both reads.
- Bounds (NREGS=18, AW=5):
  - write 0xAA to rd=20 → no entry changes (entry 4 still 0);
  - read rs1=20 → 0;
  - rd=17 read/write works normally.
- Reset mid-operation:
  - write 0x55 to rd=3 and assert `reset` for 1 cycle during RUN;
  - `readData1` and `readData2` = 0 and `ready` = 0 after that edge;
  - `regWrite` held high during CLEAR has no effect;
  - after re-sweep, entry 3 reads 0.
